// File: rtl/c4_pkg.sv
// Shared definitions for the Connect-4 win scanner: board geometry, cell
// encodings, scan directions and the scanner state encoding.
package c4_pkg;

  localparam int ROWS        = 6;
  localparam int COLS        = 7;
  localparam int WIN_LEN     = 4;
  localparam int BOARD_CELLS = ROWS * COLS;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  // Positive-side vectors (drow, dcol): H (0,+1), V (+1,0), D1 (+1,+1), D2 (+1,-1)
  typedef enum logic [1:0] {
    H  = 2'd0,
    V  = 2'd1,
    D1 = 2'd2,
    D2 = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    REQ   = 3'd2,
    CHK   = 3'd3,
    NEXT  = 3'd4,
    FIN   = 3'd5
  } state_t;

  // A piece owner is only ever player 1 or player 2.
  function automatic logic is_player(input logic [1:0] p);
    return (p == P1) || (p == P2);
  endfunction

  // Direction visiting order H -> V -> D1 -> D2.
  function automatic dir_t next_dir(input dir_t d);
    dir_t n;
    case (d)
      H:       n = V;
      V:       n = D1;
      D1:      n = D2;
      default: n = H;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/c4_step_gen.sv
// Combinational probe-address generator: latched cell + step * direction
// vector (negated on the negative side), with a board bounds test.
module c4_step_gen
  import c4_pkg::*;
(
  input  logic [2:0] row,
  input  logic [2:0] col,
  input  dir_t       dir,
  input  logic       side,
  input  logic [2:0] step,
  output logic [5:0] idx,
  output logic       in_bounds
);

  localparam logic signed [3:0] ROWS_S = 4'(ROWS);
  localparam logic signed [3:0] COLS_S = 4'(COLS);

  logic signed [3:0] delta_s;
  logic signed [3:0] drow_s;
  logic signed [3:0] dcol_s;
  logic signed [3:0] trow_s;
  logic signed [3:0] tcol_s;

  // Signed row/col offsets for the selected direction and side
  always_comb begin
    delta_s = side ? -$signed({1'b0, step}) : $signed({1'b0, step});
    drow_s  = 4'sd0;
    dcol_s  = 4'sd0;
    case (dir)
      H:  begin drow_s = 4'sd0;   dcol_s = delta_s;  end
      V:  begin drow_s = delta_s; dcol_s = 4'sd0;    end
      D1: begin drow_s = delta_s; dcol_s = delta_s;  end
      D2: begin drow_s = delta_s; dcol_s = -delta_s; end
      default: begin drow_s = 4'sd0; dcol_s = 4'sd0; end
    endcase
  end

  // Target coordinates and bounds test. Sums of 8 or 9 wrap negative in
  // four bits, so they still land on the out-of-bounds side of the test.
  always_comb begin
    trow_s    = $signed({1'b0, row}) + drow_s;
    tcol_s    = $signed({1'b0, col}) + dcol_s;
    in_bounds = (trow_s >= 4'sd0) && (trow_s < ROWS_S) &&
                (tcol_s >= 4'sd0) && (tcol_s < COLS_S);
    idx       = in_bounds ? (6'(trow_s[2:0]) * 6'(COLS) + 6'(tcol_s[2:0])) : 6'd0;
  end

endmodule

// File: rtl/c4_win_scanner.sv
// Connect-4 win/draw scanner. After each placement it walks the four line
// directions outward from the new piece through a one-read-per-probe board
// interface and reports win/winner/draw with a start/busy/done handshake.
module c4_win_scanner
  import c4_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       start,
  input  logic [2:0] place_row,
  input  logic [2:0] place_col,
  input  logic [1:0] player,
  input  logic       clear,
  output logic       rd_en,
  output logic [5:0] rd_addr,
  input  logic [1:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       win,
  output logic [1:0] winner,
  output logic       draw,
  output logic [5:0] move_cnt
);

  state_t     state_r;
  logic [2:0] row_r;
  logic [2:0] col_r;
  logic [1:0] player_r;
  dir_t       dir_r;
  logic       side_r;      // 0 = positive side, 1 = negative side
  logic [2:0] step_r;
  logic [2:0] count_r;
  logic       clr_pend_r;  // clear seen during a scan, applied when it ends

  // Coordinates of the probe the FSM is about to enter REQ with; looked up
  // one cycle early so rd_en/rd_addr can be registered.
  dir_t       probe_dir_s;
  logic       probe_side_s;
  logic [2:0] probe_step_s;
  logic [5:0] probe_idx_s;
  logic       probe_in_s;

  logic       hit_s;
  logic [2:0] count_inc_s;
  logic       win_now_s;
  logic       extend_s;

  assign hit_s       = (rd_data == player_r);
  assign count_inc_s = count_r + 3'd1;
  assign win_now_s   = hit_s && (count_inc_s == 3'(WIN_LEN));
  assign extend_s    = hit_s && !win_now_s && (step_r < 3'(WIN_LEN - 1));

  // Select the next probe: first H probe, step outward, flip side, or next direction
  always_comb begin
    probe_dir_s  = dir_r;
    probe_side_s = 1'b1;
    probe_step_s = 3'd1;
    case (state_r)
      SETUP: begin
        probe_dir_s  = H;
        probe_side_s = 1'b0;
      end
      CHK: begin
        if (extend_s) begin
          probe_side_s = side_r;
          probe_step_s = step_r + 3'd1;
        end else begin
          probe_side_s = 1'b1;
        end
      end
      NEXT: begin
        probe_dir_s  = next_dir(dir_r);
        probe_side_s = 1'b0;
      end
      default: begin
        probe_side_s = 1'b1;
      end
    endcase
  end

  c4_step_gen u_step_gen (
    .row       (row_r),
    .col       (col_r),
    .dir       (probe_dir_s),
    .side      (probe_side_s),
    .step      (probe_step_s),
    .idx       (probe_idx_s),
    .in_bounds (probe_in_s)
  );

  // Scanner FSM with registered handshake, read strobe and result flags
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_r    <= IDLE;
      row_r      <= 3'd0;
      col_r      <= 3'd0;
      player_r   <= 2'b00;
      dir_r      <= H;
      side_r     <= 1'b0;
      step_r     <= 3'd0;
      count_r    <= 3'd0;
      clr_pend_r <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= 6'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      win        <= 1'b0;
      winner     <= 2'b00;
      draw       <= 1'b0;
      move_cnt   <= 6'd0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      if (clear && (state_r != IDLE)) begin
        clr_pend_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (clear) begin
            win      <= 1'b0;
            winner   <= 2'b00;
            draw     <= 1'b0;
            move_cnt <= 6'd0;
          end else if (start && !win && !draw) begin
            row_r    <= place_row;
            col_r    <= place_col;
            player_r <= player;
            if (is_player(player) && (place_row < 3'(ROWS)) && (place_col < 3'(COLS))) begin
              busy    <= 1'b1;
              state_r <= SETUP;
            end else begin
              done    <= 1'b1;
              state_r <= FIN;
            end
          end
        end
        SETUP: begin
          move_cnt <= move_cnt + 6'd1;
          count_r  <= 3'd1;
          dir_r    <= H;
          side_r   <= 1'b0;
          step_r   <= 3'd1;
          rd_en    <= probe_in_s;
          if (probe_in_s) rd_addr <= probe_idx_s;
          state_r  <= REQ;
        end
        REQ: begin
          if (rd_en) begin
            state_r <= CHK;
          end else if (!side_r) begin
            // Out-of-bounds probe counts as a mismatch: flip to negative side
            side_r  <= 1'b1;
            step_r  <= 3'd1;
            rd_en   <= probe_in_s;
            if (probe_in_s) rd_addr <= probe_idx_s;
            state_r <= REQ;
          end else begin
            state_r <= NEXT;
          end
        end
        CHK: begin
          if (win_now_s) begin
            count_r <= count_inc_s;
            win     <= 1'b1;
            winner  <= player_r;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= FIN;
          end else if (extend_s) begin
            count_r <= count_inc_s;
            step_r  <= step_r + 3'd1;
            rd_en   <= probe_in_s;
            if (probe_in_s) rd_addr <= probe_idx_s;
            state_r <= REQ;
          end else begin
            if (hit_s) count_r <= count_inc_s;
            if (!side_r) begin
              side_r  <= 1'b1;
              step_r  <= 3'd1;
              rd_en   <= probe_in_s;
              if (probe_in_s) rd_addr <= probe_idx_s;
              state_r <= REQ;
            end else begin
              state_r <= NEXT;
            end
          end
        end
        NEXT: begin
          if (dir_r == D2) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            draw    <= (move_cnt == 6'(BOARD_CELLS));
            state_r <= FIN;
          end else begin
            dir_r   <= probe_dir_s;
            count_r <= 3'd1;
            side_r  <= 1'b0;
            step_r  <= 3'd1;
            rd_en   <= probe_in_s;
            if (probe_in_s) rd_addr <= probe_idx_s;
            state_r <= REQ;
          end
        end
        FIN: begin
          state_r    <= IDLE;
          clr_pend_r <= 1'b0;
          if (clr_pend_r || clear) begin
            win      <= 1'b0;
            winner   <= 2'b00;
            draw     <= 1'b0;
            move_cnt <= 6'd0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
